// File: rtl/spi_target_dac4091_rx.sv
`default_nettype none
// ============================================================================
// Module      : spi_target_dac4091_rx
// Description : Receive-side model of the DAC4091 SPI target. It oversamples
//               cs_n/sclk/copi in the clk domain and deserializes 16-bit
//               MSB-first frames. Each frame is validated and decoded into
//               config bits and a 12-bit code, then presented on a
//               valid/ready port.
// Ports       : clk, rst_n            - system clock, async active-low reset
//               cs_n, sclk, copi      - SPI pins (asynchronous to clk)
//               rx_code[11:0]         - frame bits [11:0]
//               rx_buf                - frame bit 14
//               rx_gain1x             - frame bit 13 (1 = 1x, 0 = 2x)
//               rx_active             - frame bit 12 (0 = shutdown)
//               rx_valid / rx_ready   - decoded-frame handshake
//               dac_level[11:0]       - modeled analog code
//               frame_err             - pulse: frame rejected
//               overrun               - pulse: unconsumed frame overwritten
//               frame_cnt[15:0]       - good-frame count (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_target_dac4091_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs_n,
    input  logic        sclk,
    input  logic        copi,
    output logic [11:0] rx_code,
    output logic        rx_buf,
    output logic        rx_gain1x,
    output logic        rx_active,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [11:0] dac_level,
    output logic        frame_err,
    output logic        overrun,
    output logic [15:0] frame_cnt
);

    localparam int FRAME_BITS = 16;
    localparam logic [4:0] c_CNT_GOOD = 5'(FRAME_BITS);
    localparam logic [4:0] c_CNT_MAX  = 5'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        S_DISARMED = 2'd0,
        S_IDLE     = 2'd1,
        S_SHIFT    = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_copi_sync;
    logic                   r_cs_prev;
    logic                   r_sclk_prev;

    // cs_n resets low in the chain so that DISARMED only exits after cs_n
    // has really been seen high, ignoring a frame in progress at reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_sync   <= '0;
            r_sclk_sync <= '0;
            r_copi_sync <= '0;
            r_cs_prev   <= 1'b0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
            r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    logic w_cs;
    logic w_copi;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_sclk_rise;

    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_copi      = r_copi_sync[SYNC_STAGES-1];
    assign w_cs_fall   = r_cs_prev & ~w_cs;
    assign w_cs_rise   = ~r_cs_prev & w_cs;
    assign w_sclk_rise = ~r_sclk_prev & r_sclk_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Frame FSM, decode and handshake
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [FRAME_BITS-1:0] r_shreg;
    logic [4:0]            r_bit_cnt;
    logic [11:0]           r_rx_code;
    logic                  r_rx_buf;
    logic                  r_rx_gain1x;
    logic                  r_rx_active;
    logic                  r_rx_valid;
    logic [11:0]           r_dac_level;
    logic                  r_frame_err;
    logic                  r_overrun;
    logic [15:0]           r_frame_cnt;

    logic w_frame_good;
    assign w_frame_good = (r_bit_cnt == c_CNT_GOOD) && !r_shreg[FRAME_BITS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_DISARMED;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_rx_code   <= '0;
            r_rx_buf    <= 1'b0;
            r_rx_gain1x <= 1'b0;
            r_rx_active <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_dac_level <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            // Handshake clear; a good frame below in the same cycle
            // overrides this and keeps rx_valid high.
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            case (r_state)
                S_DISARMED: begin
                    if (w_cs) begin
                        r_state <= S_IDLE;
                    end
                end

                S_IDLE: begin
                    if (w_cs_fall) begin
                        r_state   <= S_SHIFT;
                        r_shreg   <= '0;
                        r_bit_cnt <= '0;
                    end
                end

                S_SHIFT: begin
                    if (w_cs_rise) begin
                        r_state <= S_IDLE;
                        if (w_frame_good) begin
                            r_rx_code   <= r_shreg[11:0];
                            r_rx_buf    <= r_shreg[14];
                            r_rx_gain1x <= r_shreg[13];
                            r_rx_active <= r_shreg[12];
                            r_rx_valid  <= 1'b1;
                            // Overrun only when the old frame is not being
                            // consumed in this very cycle.
                            r_overrun   <= r_rx_valid && !rx_ready;
                            r_dac_level <= r_shreg[12] ? r_shreg[11:0] : 12'd0;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else if (w_sclk_rise) begin
                        r_shreg <= {r_shreg[FRAME_BITS-2:0], w_copi};
                        // Saturate just past a full frame so long frames
                        // stay distinguishable from exact ones.
                        if (r_bit_cnt != c_CNT_MAX) begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                end

                default: begin
                    r_state <= S_DISARMED;
                end
            endcase
        end
    end

    assign rx_code   = r_rx_code;
    assign rx_buf    = r_rx_buf;
    assign rx_gain1x = r_rx_gain1x;
    assign rx_active = r_rx_active;
    assign rx_valid  = r_rx_valid;
    assign dac_level = r_dac_level;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire
